// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction fetch over a split addr/data bus, in-order output buffer to ID.
// Optional IF_ADEF_CHECK_EN: misaligned PCs become ADEF pseudo-entries (adds id_adef_o).
module if_fetch_stage #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] if_pc_i,
  input  logic        ctl_if_valid_i,
  output logic        ctl_if_allow_nxt_pc_o,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_addr_ok_i,
  input  logic        inst_data_ok_i,
  input  logic [31:0] inst_rdata_i,
  input  logic        flush_i,
  input  logic        id_allow_in_i,
  output logic        id_valid_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
`ifdef IF_ADEF_CHECK_EN
  ,
  output logic        id_adef_o
`endif
);

  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] cnl_q, cnl_d;
  logic [CNT_W-1:0] ob_cnt_q, ob_cnt_d;
  logic [PTR_W-1:0] pw_q, pr_q;
  logic [PTR_W-1:0] ow_q, ord_q;

  logic [31:0] pend_pc [DEPTH];
  logic [31:0] ob_pc   [DEPTH];
  logic [31:0] ob_inst [DEPTH];
`ifdef IF_ADEF_CHECK_EN
  logic        ob_adef [DEPTH];
`endif

  logic [CNT_W:0] occ;
  logic room, misal, fetch_ok, req, acc;
  logic adef_push, rsp_keep, rsp_drop;
  logic push, pop;
  logic [31:0] push_pc, push_inst;

  assign occ = {1'b0, out_q} + {1'b0, cnl_q}
             + {1'b0, ob_cnt_q};
  assign room = occ < (CNT_W+1)'(DEPTH);

  assign fetch_ok = ~rst_i & ctl_if_valid_i
                  & ~flush_i & room;

`ifdef IF_ADEF_CHECK_EN
  assign misal = |if_pc_i[1:0];
  // ADEF entry waits until nothing is in flight, keeping program order
  assign adef_push = fetch_ok & misal
                   & (out_q == '0);
`else
  assign misal = 1'b0;
  assign adef_push = 1'b0;
`endif

  assign req = fetch_ok & ~misal;
  assign acc = req & inst_addr_ok_i;

  assign rsp_keep = inst_data_ok_i & (cnl_q == '0);
  assign rsp_drop = inst_data_ok_i & (cnl_q != '0);

  assign push = rsp_keep | adef_push;
  assign pop  = id_valid_o & id_allow_in_i;

  assign push_pc   = rsp_keep ? pend_pc[pr_q] : if_pc_i;
  assign push_inst = rsp_keep ? inst_rdata_i : '0;

  assign inst_req_o  = req;
  assign inst_addr_o = if_pc_i;
  assign ctl_if_allow_nxt_pc_o = acc | adef_push;

  assign id_valid_o = ob_cnt_q != '0;
  assign id_pc_o    = id_valid_o ? ob_pc[ord_q] : '0;
  assign id_inst_o  = id_valid_o ? ob_inst[ord_q] : '0;
`ifdef IF_ADEF_CHECK_EN
  assign id_adef_o  = id_valid_o & ob_adef[ord_q];
`endif

  // Counter next state: flush moves in-flight requests into the cancel count
  always_comb begin
    out_d    = out_q;
    cnl_d    = cnl_q;
    ob_cnt_d = ob_cnt_q;
    if (flush_i) begin
      out_d    = '0;
      cnl_d    = cnl_q + out_q
               - CNT_W'(inst_data_ok_i);
      ob_cnt_d = '0;
    end else begin
      out_d    = out_q + CNT_W'(acc)
               - CNT_W'(rsp_keep);
      cnl_d    = cnl_q - CNT_W'(rsp_drop);
      ob_cnt_d = ob_cnt_q + CNT_W'(push)
               - CNT_W'(pop);
    end
  end

  // Counters and FIFO pointers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_q    <= '0;
      cnl_q    <= '0;
      ob_cnt_q <= '0;
      pw_q     <= '0;
      pr_q     <= '0;
      ow_q     <= '0;
      ord_q    <= '0;
    end else begin
      out_q    <= out_d;
      cnl_q    <= cnl_d;
      ob_cnt_q <= ob_cnt_d;
      if (flush_i) begin
        pw_q  <= '0;
        pr_q  <= '0;
        ow_q  <= '0;
        ord_q <= '0;
      end else begin
        if (acc)      pw_q  <= pw_q + PTR_W'(1);
        if (rsp_keep) pr_q  <= pr_q + PTR_W'(1);
        if (push)     ow_q  <= ow_q + PTR_W'(1);
        if (pop)      ord_q <= ord_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are only meaningful behind the counters
  always_ff @(posedge clk_i) begin
    if (acc) pend_pc[pw_q] <= if_pc_i;
    if (push) begin
      ob_pc[ow_q]   <= push_pc;
      ob_inst[ow_q] <= push_inst;
`ifdef IF_ADEF_CHECK_EN
      ob_adef[ow_q] <= ~rsp_keep;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed + random checks of if_fetch_stage
// Reference model tracks bus requests by flush epoch.
module tb_if_fetch_stage;

  localparam int DEPTH = 2;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        ctl_valid;
  logic        allow_nxt;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        flush;
  logic        allow_in;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  if_fetch_stage #(.DEPTH(2), .PTR_W(1)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .if_pc_i               (if_pc),
    .ctl_if_valid_i        (ctl_valid),
    .ctl_if_allow_nxt_pc_o (allow_nxt),
    .inst_req_o            (inst_req),
    .inst_addr_o           (inst_addr),
    .inst_addr_ok_i        (addr_ok),
    .inst_data_ok_i        (data_ok),
    .inst_rdata_i          (rdata),
    .flush_i               (flush),
    .id_allow_in_i         (allow_in),
    .id_valid_o            (id_valid),
    .id_pc_o               (id_pc),
    .id_inst_o             (id_inst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          ep;
  } bus_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  bus_t bus_q[$];
  ent_t ob_q[$];
  int   epoch;
  logic [31:0] pc;

  int tests;
  int fails;

  logic        s_req, s_allow, s_val;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %08h want %08h",
             tag, obs, exp);
    end
  endtask

  task automatic step(input logic v,
                      input logic aok,
                      input logic dok,
                      input logic [31:0] rd,
                      input logic fl,
                      input logic ain);
    int   occ;
    logic e_req, e_allow, e_val;
    bus_t b;
    @(negedge clk);
    ctl_valid = v;
    addr_ok   = aok;
    data_ok   = dok && (bus_q.size() > 0);
    rdata     = rd;
    flush     = fl;
    allow_in  = ain;
    if_pc     = pc;
    #1;
    occ     = bus_q.size() + ob_q.size();
    e_req   = v & ~fl & (occ < DEPTH);
    e_allow = e_req & aok;
    e_val   = ob_q.size() > 0;
    s_req   = inst_req;
    s_allow = allow_nxt;
    s_val   = id_valid;
    s_addr  = inst_addr;
    s_pc    = id_pc;
    s_inst  = id_inst;
    chk("req", s_req, e_req);
    chk("allow_nxt_pc", s_allow, e_allow);
    chk("addr", s_addr, pc);
    chk("id_valid", s_val, e_val);
    if (e_val) begin
      chk("id_pc", s_pc, ob_q[0].pc);
      chk("id_inst", s_inst, ob_q[0].inst);
    end
    @(posedge clk);
    if (e_val && ain) void'(ob_q.pop_front());
    if (data_ok) begin
      b = bus_q.pop_front();
      if (!fl && b.ep == epoch)
        ob_q.push_back('{b.pc, rdata});
    end
    if (fl) begin
      ob_q.delete();
      epoch++;
    end
    if (e_allow) begin
      bus_q.push_back('{pc, epoch});
      pc = pc + 32'd4;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    ctl_valid = 1'b1;
    addr_ok   = 1'b1;
    data_ok   = 1'b0;
    flush     = 1'b0;
    allow_in  = 1'b1;
    if_pc     = pc;
    #1;
    chk("rst_req", inst_req, 0);
    chk("rst_allow", allow_nxt, 0);
    chk("rst_valid", id_valid, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_inst", id_inst, 0);
    bus_q.delete();
    ob_q.delete();
    @(negedge clk);
    ctl_valid = 1'b0;
    addr_ok   = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 1, $urandom(), 0, 1);
  endtask

  logic [31:0] st_pc;

  initial begin
    tests = 0;
    fails = 0;
    epoch = 0;
    rst = 1'b1;
    ctl_valid = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = '0;
    flush = 1'b0;
    allow_in = 1'b0;
    pc = 32'h1c00_0000;
    if_pc = pc;

    do_reset();

    step(1, 1, 0, 0, 0, 0);
    chk("t1_allow", s_allow, 1);
    step(0, 0, 1, 32'h0280_0000, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t1_valid", s_val, 1);
    chk("t1_pc", s_pc, 32'h1c00_0000);
    chk("t1_inst", s_inst, 32'h0280_0000);
    drain(3);

    pc = 32'h1c00_0000;
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 32'h1111_0000, 0, 0);
    step(1, 1, 1, 32'h2222_0004, 0, 0);
    chk("b2b_block", s_req, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("b2b_block2", s_req, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("b2b_head0", s_pc, 32'h1c00_0000);
    step(1, 0, 0, 0, 0, 1);
    chk("b2b_head1", s_pc, 32'h1c00_0004);
    chk("b2b_reissue", s_req, 1);
    drain(4);

    pc = 32'h1c00_0040;
    st_pc = pc;
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 1);
      chk("stall_req", s_req, 1);
      chk("stall_addr", s_addr, st_pc);
      chk("stall_allow", s_allow, 0);
    end
    step(1, 1, 0, 0, 0, 1);
    chk("stall_acc", s_allow, 1);
    step(0, 0, 1, 32'h3333_3333, 0, 1);
    drain(3);

    pc = 32'h1c00_0080;
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 32'hdead_beef, 0, 1);
    chk("fl_valid0", s_val, 0);
    step(0, 0, 1, 32'h1234_5678, 0, 1);
    chk("fl_valid1", s_val, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("fl_valid2", s_val, 0);
    pc = 32'h1c00_0100;
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 32'h0abc_0001, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("fl_new_pc", s_pc, 32'h1c00_0100);
    chk("fl_new_inst", s_inst, 32'h0abc_0001);
    drain(3);

    pc = 32'h1c00_0200;
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 1);
    step(0, 0, 1, 32'h5555_5555, 1, 1);
    step(0, 0, 1, 32'h6666_6666, 0, 1);
    chk("fd_valid0", s_val, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("fd_valid1", s_val, 0);
    chk("fd_room", s_req, 0);
    step(1, 0, 0, 0, 0, 1);
    chk("fd_reissue", s_req, 1);
    drain(3);

    for (int i = 0; i < 600; i++) begin
      logic fl;
      if (i == 300) do_reset();
      fl = ($urandom() % 16) == 0;
      step(($urandom() % 4) != 0,
           ($urandom() % 3) != 0,
           ($urandom() % 2) != 0,
           $urandom(),
           fl,
           ($urandom() % 4) != 0);
      if (fl) pc = $urandom() & 32'hffff_fffc;
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage, directly downstream of the PC register.
- Takes the current fetch PC and its valid flag, and issues requests to the instruction SRAM-like bus (addr/data split handshake).
- Tracks in-flight requests, buffers returned instructions with their PCs, and presents them in order to ID with a valid/allow-in handshake.
- Handles pipeline flush (branch/exception redirect) by discarding buffered and in-flight fetches.

Parameters:
- DEPTH, 2, max fetch slots: in-flight requests plus buffered instructions; power of two, ≥2.
- PTR_W, 1, log2(DEPTH); pointer width for the pending-PC and output FIFOs.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- if_pc_i  in  32  current fetch PC from PC register
- ctl_if_valid_i  in  1  if_pc_i holds a valid fetch address
- ctl_if_allow_nxt_pc_o  out  1  PC register may advance this cycle
- inst_req_o  out  1  fetch request valid
- inst_addr_o  out  32  fetch address
- inst_addr_ok_i  in  1  bus accepted request this cycle
- inst_data_ok_i  in  1  bus returns instruction this cycle, in request order
- inst_rdata_i  in  32  returned instruction word
- flush_i  in  1  redirect: discard all fetches
- id_allow_in_i  in  1  ID accepts entry this cycle
- id_valid_o  out  1  output entry valid
- id_pc_o  out  32  PC of output entry
- id_inst_o  out  32  instruction of output entry

Behaviour:
- Reset is asynchronous and active-high on rst_i; clock is clk_i. While rst_i=1, all state clears: outstanding=0, cancel_cnt=0, buffer empty, FIFO pointers 0. Outputs during reset: inst_req_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0, ctl_if_allow_nxt_pc_o=0.
- Occupancy: occ = outstanding + buf_cnt + cancel_cnt, never exceeds DEPTH.
- Request issue: inst_req_o = ctl_if_valid_i & ~flush_i & (occ < DEPTH).
  - inst_addr_o = if_pc_i (combinational, no latency).
  - The request holds until inst_addr_ok_i; address and req are stable while pending only if the PC register holds.
- Address handshake: ctl_if_allow_nxt_pc_o = inst_req_o & inst_addr_ok_i. The PC register advances exactly once per accepted request.
- On acceptance, if_pc_i is pushed into the pending-PC FIFO and outstanding increments.
- Response, normal case (cancel_cnt=0): on inst_data_ok_i:
  - pop the pending-PC FIFO;
  - push {pc, inst_rdata_i} into the output buffer;
  - outstanding decrements.
  - The buffer cannot be full, because slots are reserved at issue.
- Response during cancel (cancel_cnt>0): inst_data_ok_i decrements cancel_cnt. Data is dropped and no pending-PC pop occurs, since that FIFO was already cleared.
- Output: id_valid_o = buf_cnt != 0; id_pc_o/id_inst_o = buffer head. Head pops when id_valid_o & id_allow_in_i.
- Output latency: data returned at cycle N is visible on id_* at N+1.
- Simultaneous events:
  - Accept, response and ID pop in the same cycle are all legal. Counters update by the net of increments and decrements.
  - No same-cycle bypass from a response to id_*.
- Flush: on flush_i=1:
  - the output buffer empties;
  - the pending-PC FIFO clears;
  - no request is issued that cycle;
  - cancel_cnt <= cancel_cnt + outstanding - inst_data_ok_i;
  - outstanding <= 0.
  - id_valid_o=0 from the next cycle. A data_ok in the flush cycle is discarded.
- Flush during cancel accumulates correctly per the formula above.
- After flush, new requests may issue once occ < DEPTH; earlier responses are always discarded before new ones land.
- Reset mid-transaction: all state clears immediately. The bus is assumed to be reset together with this block.

Optional Feature:
- Macro: IF_ADEF_CHECK_EN.
- When defined:
  - if_pc_i[1:0] != 0 with ctl_if_valid_i issues no bus request.
  - If buffer space exists (occ < DEPTH), a pseudo-entry {pc, 32'h0, adef=1} is pushed directly into the output buffer, and ctl_if_allow_nxt_pc_o=1 that cycle.
  - Extra output port id_adef_o (1 bit, reset 0) marks the head entry.
- When undefined: no check, no id_adef_o port, misaligned PCs are fetched as-is.

Test Plan:
- Reset release, pc=0x1c000000 valid, addr_ok same cycle, data_ok next cycle with 0x02800000 → allow_nxt_pc=1 at cycle 0; id_valid=1, id_pc=0x1c000000, id_inst=0x02800000 at cycle 2.
- Back-to-back: pcs 0x1c000000/0x1c000004 accepted, id_allow_in=0 → third request blocked (inst_req_o=0, occ=2); raise allow_in → entries drain in order and req reasserts.
- Bus stall: addr_ok=0 for 3 cycles → inst_req_o held, addr stable, allow_nxt_pc=0; accept on cycle 4 → single PC advance.
- Flush with 2 outstanding → cancel_cnt=2, id_valid=0; two later data_ok (0xdeadbeef, 0x12345678) dropped; a new fetch to 0x1c000100 returns and is output correctly.
- Flush in the same cycle as a data_ok with 2 outstanding → cancel_cnt=1; that data and the next one are both discarded.
- With IF_ADEF_CHECK_EN: pc=0x1c000002 valid → inst_req_o=0, id_valid=1, id_adef_o=1, id_pc=0x1c000002, id_inst=0.
